series_initiator: RTL
=====================

SERIES_INITIATOR -- requirements
Module: series_initiator

Interface
REQ-001 SHALL have parameters: DW, default 16, operand width; RW, default 32, result width; DEPTH, default 4, input queue entries (power of 2); START_CYC, default 2, start pulse length; TIMEOUT, default 255, max wait cycles per phase.
REQ-002 SHALL have ports, one per line:
  clk  in  1  clock, rising-edge
  rst  in  1  reset, asynchronous, active-high
  in_valid  in  1  operand offered
  in_ready  out  1  queue not full
  in_x  in  DW  operand
  unit_start  out  1  start to series compute unit
  unit_x  out  DW  operand presented to unit, stable from START until capture
  unit_done  in  1  unit idle/done level (high when idle)
  unit_result  in  RW  unit result, valid while unit_done high after completion
  out_valid  out  1  result available
  out_ready  in  1  consumer accepts
  out_x  out  DW  operand that produced out_result
  out_result  out  RW  captured result
  busy  out  1  FSM not in IDLE or queue non-empty
  timeout_err  out  1  sticky, set on any phase timeout

Function
REQ-003 Input queue SHALL accept in_x when in_valid and in_ready are both high on a clock edge; in_ready = queue not full; FIFO order.
REQ-004 Simultaneous push and pop on a full queue SHALL NOT be permitted (in_ready low when full); simultaneous push and pop on a non-full queue SHALL both take effect, count unchanged.
REQ-005 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-006 FSM states SHALL be: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, PRESENT.
REQ-007 IDLE -> LOAD when queue non-empty and unit_done high; otherwise remain.
REQ-008 LOAD SHALL pop one entry into unit_x register; -> START next cycle.
REQ-009 START SHALL drive unit_start high for exactly START_CYC cycles, then -> WAIT_ACK with unit_start low.
REQ-010 WAIT_ACK SHALL wait for unit_done low (unit left idle) -> WAIT_DONE; this prevents capturing the stale idle-level done.
REQ-011 WAIT_DONE SHALL wait for unit_done high; on that edge capture unit_result into out_result and unit_x into out_x, -> PRESENT.
REQ-012 PRESENT SHALL hold out_valid high and out_result/out_x stable until out_ready high; on handshake -> IDLE, out_valid low next cycle.
REQ-013 A per-phase counter SHALL clear on entry to WAIT_ACK and WAIT_DONE and increment each cycle in them; reaching TIMEOUT SHALL set timeout_err, discard the operand, and -> IDLE without asserting out_valid.
REQ-014 Minimum latency from pop (LOAD) to out_valid SHALL be START_CYC + 3 cycles plus unit compute time.
REQ-015 unit_start SHALL be low in every state except START.
REQ-016 in_ready SHALL remain functional in all FSM states (queue fills during computation).

Reset
REQ-017 rst SHALL asynchronously force: state IDLE, queue empty (count 0, pointers 0), unit_start 0, unit_x 0, out_valid 0, out_x 0, out_result 0, timeout_err 0, phase counter 0.
REQ-018 Reset mid-operation SHALL drop any in-flight operand and queued entries; no output SHALL be produced for them.
REQ-019 timeout_err SHALL clear only on rst.

Structure
REQ-020 FSM state enumeration and default parameter constants SHALL reside in a shared package series_pkg.
REQ-021 The input queue SHALL be a separate sub-module sync_fifo (parameters DW, DEPTH); FSM, counters and output registers in series_initiator.

Verification
REQ-022 Single op: push x=3, unit model done after 10 cycles returning 0x0000_0014 -> unit_start high 2 cycles, out_valid with out_x=3, out_result=0x14.
REQ-023 Queue full: push 5 operands back-to-back with unit busy -> in_ready low after 4th, 5th accepted only after first LOAD; results in order.
REQ-024 Backpressure: out_ready low 20 cycles -> out_result stable, no new unit_start issued until handshake.
REQ-025 Timeout: unit model never drops unit_done -> after 255 cycles in WAIT_ACK, timeout_err=1, out_valid never set, FSM returns IDLE, next operand processed.
REQ-026 Reset mid-WAIT_DONE with 2 queued -> all outputs zero immediately, busy=0 after release, no out_valid.
REQ-027 Wrap: push/pop 9 operands through DEPTH=4 queue -> all 9 results in order, no loss or duplication.

Source files
------------

// File: rtl/series_pkg.sv
// series_pkg: shared FSM state encoding and default parameters for the series initiator.
package series_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, PRESENT} state_t;
  localparam int DW_DEF        = 16;
  localparam int RW_DEF        = 32;
  localparam int DEPTH_DEF     = 4;
  localparam int START_CYC_DEF = 2;
  localparam int TIMEOUT_DEF   = 255;
endpackage

// File: rtl/series_initiator_fifo.sv
// sync_fifo: power-of-2 deep operand queue; ignores push when full and pop when empty.
module sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout  = mem[rd_q];
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end
endmodule

// File: rtl/series_initiator.sv
// series_initiator: queues operands and sequences them one at a time through a
// start/done series compute unit, presenting each result with its operand.
module series_initiator
  import series_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int RW        = RW_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int START_CYC = START_CYC_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_x,
  output logic          unit_start,
  output logic [DW-1:0] unit_x,
  input  logic          unit_done,
  input  logic [RW-1:0] unit_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_x,
  output logic [RW-1:0] out_result,
  output logic          busy,
  output logic          timeout_err
);
  localparam int CW = $clog2((TIMEOUT > START_CYC ? TIMEOUT : START_CYC) + 1);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] unit_x_q, unit_x_d, out_x_q, out_x_d, fifo_dout;
  logic [RW-1:0] out_result_q, out_result_d;
  logic          err_q, err_d, pop, full, empty;
  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(in_valid), .pop(pop), .din(in_x),
    .dout(fifo_dout), .full(full), .empty(empty)
  );
  assign in_ready    = !full;
  assign unit_start  = state_q == START;
  assign unit_x      = unit_x_q;
  assign out_valid   = state_q == PRESENT;
  assign out_x       = out_x_q;
  assign out_result  = out_result_q;
  assign busy        = state_q != IDLE || !empty;
  assign timeout_err = err_q;
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    unit_x_d     = unit_x_q;
    out_x_d      = out_x_q;
    out_result_d = out_result_q;
    err_d        = err_q;
    pop          = 1'b0;
    case (state_q)
      IDLE: state_d = !empty && unit_done ? LOAD : IDLE;
      LOAD: begin
        pop      = 1'b1;
        unit_x_d = fifo_dout;
        cnt_d    = '0;
        state_d  = START;
      end
      START: if (cnt_q == CW'(START_CYC - 1)) begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      // done must fall first so the idle-level done is never taken as completion
      WAIT_ACK: if (!unit_done) begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end else if (cnt_d == CW'(TIMEOUT)) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      WAIT_DONE: if (unit_done) begin
        out_result_d = unit_result;
        out_x_d      = unit_x_q;
        state_d      = PRESENT;
      end else if (cnt_d == CW'(TIMEOUT)) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      PRESENT: state_d = out_ready ? IDLE : PRESENT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      unit_x_q     <= '0;
      out_x_q      <= '0;
      out_result_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      unit_x_q     <= unit_x_d;
      out_x_q      <= out_x_d;
      out_result_q <= out_result_d;
      err_q        <= err_d;
    end
  end
endmodule
